// File: rtl/instruction_encoder.sv
// instruction_encoder: packs MIPS32 encode requests into 32-bit words behind a small output FIFO.
// Define INSTR_ENCODER_NOP_PAD_EN to append a delay-slot NOP after every jr/beq/j/jal.
module instruction_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm16,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_pulse,
  output logic [CNT_W-1:0] enc_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  typedef enum logic {IDLE, PAD} state_t;
  state_t            state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q;
  logic [CNT_W-1:0]  enc_q;
  logic              accept, op_ok, push_req, pad_push, push, pop;
  logic [31:0]       word, push_word;
  always_comb begin
    word = '0;
    case (in_op)
      4'd0:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h21};
      4'd1:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h23};
      4'd2:    word = {6'h00, in_rs, 15'b0, 6'h08};
      4'd3:    word = 32'h0000000c;
      4'd4:    word = {6'h0d, in_rs, in_rt, in_imm16};
      4'd5:    word = {6'h0f, 5'b0, in_rt, in_imm16};
      4'd6:    word = {6'h23, in_rs, in_rt, in_imm16};
      4'd7:    word = {6'h2b, in_rs, in_rt, in_imm16};
      4'd8:    word = {6'h04, in_rs, in_rt, in_imm16};
      4'd9:    word = {6'h02, in_target};
      4'd10:   word = {6'h03, in_target};
      default: word = '0;
    endcase
  end
  assign op_ok     = in_op <= 4'd10;
  assign accept    = in_valid && in_ready;
  assign push_req  = accept && op_ok;
  assign push      = push_req || pad_push;
  assign push_word = pad_push ? 32'h0 : word;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign err_pulse = err_q;
  assign enc_count = enc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
`ifdef INSTR_ENCODER_NOP_PAD_EN
  logic is_cf;
  assign is_cf = in_op == 4'd2 || in_op == 4'd8 || in_op == 4'd9 || in_op == 4'd10;
  always_comb
    state_d = state_q == IDLE ? ((push_req && is_cf) ? PAD : IDLE) : (pad_push ? IDLE : PAD);
`else
  always_comb state_d = IDLE;
`endif
  // A pending pad NOP waits for space and blocks new requests meanwhile.
  always_comb begin
    in_ready = state_q == IDLE && cnt_q < DEPTH;
    pad_push = state_q == PAD && cnt_q < DEPTH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      enc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      err_q    <= accept && !op_ok;
      enc_q    <= enc_q + CNT_W'(push);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= push_word;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed vector table, hand sequences and a random run against a queue model.
// Expectations follow INSTR_ENCODER_NOP_PAD_EN when it is defined for the build.
module tb_instruction_encoder;
  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm16, enc_count;
  logic [25:0] in_target;
  logic [31:0] out_instr;
  int tests = 0, fails = 0, exp_cnt = 0;
  logic [31:0] got[$], expq[$];
`ifdef INSTR_ENCODER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef struct {
    int op, rs, rt, rd, imm, tgt;
    logic [31:0] exp;
  } vec_t;
  vec_t v[11];

  instruction_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm16(in_imm16), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(int unsigned op, rs, rt, rd, imm, tgt);
    int unsigned r = rs << 21, t = rt << 16, d = rd << 11;
    case (op)
      0: return r | t | d | 32'h21;
      1: return r | t | d | 32'h23;
      2: return r | 32'h8;
      3: return 32'hc;
      4: return (32'd13 << 26) | r | t | imm;
      5: return (32'd15 << 26) | t | imm;
      6: return (32'd35 << 26) | r | t | imm;
      7: return (32'd43 << 26) | r | t | imm;
      8: return (32'd4 << 26) | r | t | imm;
      9: return (32'd2 << 26) | tgt;
      10: return (32'd3 << 26) | tgt;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_cf(int op);
    return op == 2 || (op >= 8 && op <= 10);
  endfunction

  task automatic model_push(input int op, rs, rt, rd, imm, tgt);
    if (op <= 10) begin
      expq.push_back(ref_enc(op, rs, rt, rd, imm, tgt));
      exp_cnt++;
      if (PAD_EN && is_cf(op)) begin
        expq.push_back(32'h0);
        exp_cnt++;
      end
    end
  endtask

  // Holds the request until accepted; returns #1 after the accepting edge.
  task automatic send(input int op, rs, rt, rd, imm, tgt, input bit rnd);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm16 = 16'(imm); in_target = 26'(tgt); in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    got.delete();
    expq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_instr"}, out_instr, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_enc_count"}, enc_count, 0);
  endtask

  // Pop collector plus hold check: a stalled head must not change at the next edge.
  logic        pstall;
  logic [31:0] pinstr;
  always @(posedge clk) begin
    if (rst) pstall <= 1'b0;
    else begin
      if (pstall) check("stall_hold", {out_valid, out_instr}, {1'b1, pinstr});
      if (out_valid && out_ready) got.push_back(out_instr);
      pstall <= out_valid && !out_ready;
      pinstr <= out_instr;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_imm16 = '0; in_target = '0;
    #12;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    v[0]  = '{0, 1, 2, 3, 0, 0, 32'h00221821};
    v[1]  = '{4, 0, 5, 0, 'h1234, 0, 32'h34051234};
    v[2]  = '{5, 3, 8, 0, 'hdead, 0, 32'h3c08dead};
    v[3]  = '{6, 29, 9, 0, 4, 0, 32'h8fa90004};
    v[4]  = '{7, 29, 9, 0, 4, 0, 32'hafa90004};
    v[5]  = '{1, 4, 5, 6, 'hffff, 'h3ffffff, 32'h00853023};
    v[6]  = '{2, 31, 7, 7, 1, 0, 32'h03e00008};
    v[7]  = '{3, 31, 31, 31, 'hffff, 'h3ffffff, 32'h0000000c};
    v[8]  = '{8, 1, 2, 0, 'hffff, 0, 32'h1022ffff};
    v[9]  = '{9, 31, 0, 0, 0, 'h3ffffff, 32'h0bffffff};
    v[10] = '{10, 0, 0, 0, 0, 'h0100000, 32'h0c100000};
    foreach (v[i]) begin
      send(v[i].op, v[i].rs, v[i].rt, v[i].rd, v[i].imm, v[i].tgt, 1'b0);
      exp_cnt++;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_instr", i), out_instr, v[i].exp);
      if (PAD_EN && is_cf(v[i].op)) begin
        @(posedge clk); #1;
        exp_cnt++;
        check($sformatf("vec%0d_pad", i), {out_valid, out_instr}, {1'b1, 32'h0});
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d_drained", i), out_valid, 0);
      check($sformatf("vec%0d_count", i), enc_count, 16'(exp_cnt));
    end

    // Backpressure: fill, hold a third request, then drain with push+pop on one edge.
    out_ready = 1'b0;
    send(4, 0, 1, 0, 'h0001, 0, 1'b0);
    check("bp_ready1", in_ready, 1);
    send(5, 0, 2, 0, 'h0002, 0, 1'b0);
    check("bp_full_ready", in_ready, 0);
    in_op = 4'd0; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_head", out_instr, 32'h34010001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_pop_no_accept", enc_count, 16'(exp_cnt + 2));
    check("bp_head_b", out_instr, 32'h3c020002);
    check("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt += 3;
    check("bp_head_c", {out_valid, out_instr}, {1'b1, 32'h00642821});
    check("bp_pushpop_count", enc_count, 16'(exp_cnt));
    @(posedge clk); #1;
    check("bp_empty", {out_valid, out_instr}, {1'b0, 32'h0});

    // Invalid opcode.
    send(15, 1, 2, 3, 'h1234, 5, 1'b0);
    check("inv_err_hi", err_pulse, 1);
    check("inv_no_word", out_valid, 0);
    check("inv_count", enc_count, 16'(exp_cnt));
    @(posedge clk); #1;
    check("inv_err_lo", err_pulse, 0);
    check("inv_still_empty", out_valid, 0);

    // Control-flow pair: beq then jal.
    do_reset();
    send(8, 1, 2, 0, 'hffff, 0, 1'b0);
    send(10, 0, 0, 0, 0, 'h0100000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    model_push(8, 1, 2, 0, 'hffff, 0);
    model_push(10, 0, 0, 0, 0, 'h0100000);
    check("cf_words", got.size(), PAD_EN ? 4 : 2);
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("cf_word%0d", i), got[i], expq[i]);
    check("cf_count", enc_count, PAD_EN ? 4 : 2);

    // Random requests with random backpressure against the queue model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op, rs, rt, rd, imm, tgt;
      op = $urandom_range(0, 15); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
      rd = $urandom_range(0, 31); imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 26'h3ffffff);
      send(op, rs, rt, rd, imm, tgt, 1'b1);
      check("rnd_err", err_pulse, op > 10);
      model_push(op, rs, rt, rd, imm, tgt);
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rnd_nwords", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("rnd_word%0d", i), got[i], expq[i]);
    check("rnd_count", enc_count, 16'(exp_cnt));

    // Asynchronous reset with the FIFO full (and a pad pending when enabled).
    do_reset();
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 1'b0);
    send(2, 31, 0, 0, 0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(4, 0, 5, 0, 'h1234, 0, 1'b0);
    check("postrst_word", {out_valid, out_instr}, {1'b1, 32'h34051234});
    @(posedge clk); #1;
    check("postrst_no_pad", out_valid, 0);
    check("postrst_count", enc_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
